// File: rtl/jt007232_romarb.sv
// ============================================================================
// Module   : jt007232_romarb
// Function : Shared ROM bus arbiter for the two 007232 PCM channels; each
//            channel holds a one-byte tagged cache, misses go round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jt007232_romarb #(
    parameter int BSEL = 0
) (
    input  logic        rst,
    input  logic        clk,
    input  logic [16:0] roma_addr,
    input  logic        roma_cs,
    output logic        roma_ok,
    output logic [7:0]  roma_dout,
    input  logic [16:0] romb_addr,
    input  logic        romb_cs,
    output logic        romb_ok,
    output logic [7:0]  romb_dout,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [7:0]  rom_data
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [16:0] r_tag_a, r_tag_b, r_req_addr;
    logic [7:0]  r_data_a, r_data_b;
    logic        r_valid_a, r_valid_b;
    logic        r_last;     // 0 = channel A, 1 = channel B
    logic        r_owner;
    logic [17:0] r_rom_addr;
    logic        r_rom_cs;

    logic        w_hit_a, w_hit_b, w_miss_a, w_miss_b, w_pick, w_chan_bit;
    logic [16:0] w_pick_addr;

    assign w_hit_a  = roma_cs && r_valid_a && (r_tag_a == roma_addr);
    assign w_hit_b  = romb_cs && r_valid_b && (r_tag_b == romb_addr);
    assign w_miss_a = roma_cs && !w_hit_a;
    assign w_miss_b = romb_cs && !w_hit_b;

    // With both channels missing, the one not served last wins
    assign w_pick      = (w_miss_a && w_miss_b) ? ~r_last : w_miss_b;
    assign w_pick_addr = w_pick ? romb_addr : roma_addr;
    assign w_chan_bit  = (BSEL != 0) ? w_pick : 1'b0;

    assign roma_ok   = w_hit_a;
    assign romb_ok   = w_hit_b;
    assign roma_dout = r_data_a;
    assign romb_dout = r_data_b;
    assign rom_addr  = r_rom_addr;
    assign rom_cs    = r_rom_cs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tag_a    <= '0;
            r_tag_b    <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_valid_a  <= 1'b0;
            r_valid_b  <= 1'b0;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_req_addr <= '0;
            r_rom_addr <= '0;
            r_rom_cs   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss_a || w_miss_b) begin
                        r_owner    <= w_pick;
                        r_last     <= w_pick;
                        r_req_addr <= w_pick_addr;
                        r_rom_addr <= {w_chan_bit, w_pick_addr};
                        r_rom_cs   <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The fill always stores the launched address, never the live one
                    if (rom_ok) begin
                        if (r_owner) begin
                            r_data_b  <= rom_data;
                            r_tag_b   <= r_req_addr;
                            r_valid_b <= 1'b1;
                        end else begin
                            r_data_a  <= rom_data;
                            r_tag_a   <= r_req_addr;
                            r_valid_a <= 1'b1;
                        end
                        r_rom_cs <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_rom_cs <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
